// File: rtl/dual_chamber_pacer.sv
// Dual-chamber pacing controller: escape timers, refractory blanking,
// runtime DDD/VVI select and saturating pace statistics.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   A_WAIT  | waiting for an atrial sense, atrial escape timer running
//   A_PACE  | driving the atrial pace pulse
//   V_WAIT  | waiting for a ventricular sense (AV delay, or VV in VVI)
//   V_PACE  | driving the ventricular pace pulse
//   REFRACT | blanking after a ventricular event, senses ignored
//
// The timer counts the cycles remaining in the current state and exits
// when it reaches zero. Loading lim-1 on entry also captures the limit, so
// later changes on the limit inputs have no effect until the next entry.
module dual_chamber_pacer #(
  parameter int CNT_W   = 16,
  parameter int PACE_W  = 2,
  parameter int REF_CYC = 8,
  parameter int STAT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sa_i,
  input  logic              sv_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  va_limit_i,
  input  logic [CNT_W-1:0]  av_limit_i,
  output logic              pa_o,
  output logic              pv_o,
  output logic              refr_o,
  output logic [2:0]        state_o,
  output logic [STAT_W-1:0] apace_cnt_o,
  output logic [STAT_W-1:0] vpace_cnt_o
);

  typedef enum logic [2:0] {
    A_WAIT  = 3'd0,
    A_PACE  = 3'd1,
    V_WAIT  = 3'd2,
    V_PACE  = 3'd3,
    REFRACT = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PACE_LD = CNT_W'(PACE_W - 1);
  localparam logic [CNT_W-1:0] REF_LD  = CNT_W'(REF_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [STAT_W-1:0] apace_q, vpace_q;
  logic              apace_inc, vpace_inc;
  logic              tc;

  // A zero limit behaves as one cycle.
  function automatic logic [CNT_W-1:0] wait_ld(input logic [CNT_W-1:0] lim);
    return (lim == '0) ? '0 : lim - CNT_W'(1);
  endfunction

  assign tc = (timer_q == '0);

  // State and remaining-cycle timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REFRACT;
      timer_q <= REF_LD;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and timer reload; a sense beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q - CNT_W'(1);
    apace_inc = 1'b0;
    vpace_inc = 1'b0;
    case (state_q)
      A_WAIT: begin
        if (sa_i) begin
          state_d = V_WAIT;
          timer_d = wait_ld(av_limit_i);
        end else if (tc) begin
          state_d   = A_PACE;
          timer_d   = PACE_LD;
          apace_inc = 1'b1;
        end
      end
      A_PACE: begin
        if (tc) begin
          state_d = V_WAIT;
          timer_d = wait_ld(av_limit_i);
        end
      end
      V_WAIT: begin
        if (sv_i) begin
          state_d = REFRACT;
          timer_d = REF_LD;
        end else if (tc) begin
          state_d   = V_PACE;
          timer_d   = PACE_LD;
          vpace_inc = 1'b1;
        end
      end
      V_PACE: begin
        if (tc) begin
          state_d = REFRACT;
          timer_d = REF_LD;
        end
      end
      REFRACT: begin
        // VVI escape and DDD atrial escape both run off va_limit.
        if (tc) begin
          state_d = mode_i ? V_WAIT : A_WAIT;
          timer_d = wait_ld(va_limit_i);
        end
      end
      default: begin
        state_d = REFRACT;
        timer_d = REF_LD;
      end
    endcase
  end

  // Saturating pace counters, bumped on entry to a pace state.
  always_ff @(posedge clk) begin
    if (rst) begin
      apace_q <= '0;
      vpace_q <= '0;
    end else begin
      if (apace_inc && (apace_q != '1)) apace_q <= apace_q + STAT_W'(1);
      if (vpace_inc && (vpace_q != '1)) vpace_q <= vpace_q + STAT_W'(1);
    end
  end

  assign pa_o        = (state_q == A_PACE);
  assign pv_o        = (state_q == V_PACE);
  assign refr_o      = (state_q == REFRACT);
  assign state_o     = state_q;
  assign apace_cnt_o = apace_q;
  assign vpace_cnt_o = vpace_q;

endmodule
